// File: rtl/crc_serial_engine_pkg.sv
// crc_pkg: shared state encoding and sizing helpers for the serial CRC engine
package crc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SHIFT} state_t;
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
  localparam int CRC_W_DEF = 8;
  localparam int CNT_W_DEF = cnt_width(CRC_W_DEF);
endpackage

// File: rtl/crc_serial_engine_lfsr_step.sv
// crc_lfsr_step: one bit of a Galois right-shift LFSR update
module crc_lfsr_step #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'b01000100
) (
  input  logic             d,
  input  logic [WIDTH-1:0] lfsr_in,
  output logic [WIDTH-1:0] lfsr_out
);
  logic fb;
  assign fb = d ^ lfsr_in[0];
  assign lfsr_out = {fb, lfsr_in[WIDTH-1:1] ^ (TAPS[WIDTH-2:0] & {(WIDTH-1){fb}})};
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: multi-bit-per-beat CRC generator/checker with LSB-first serial CRC output
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'b01000100,
  parameter logic [WIDTH-1:0] SEED = '0,
  parameter int DIN_W = 1,
  parameter logic [WIDTH-1:0] XOR_OUT = '0,
  parameter logic [WIDTH-1:0] RESIDUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] data_in,
  input  logic             data_valid,
  input  logic             data_last,
  input  logic             mode_check,
  input  logic             abort,
  output logic             data_ready,
  output logic             crc_bit,
  output logic             crc_valid,
  output logic             crc_done,
  output logic             crc_err
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] lfsr, shreg, next_lfsr, gen_val;
  logic [DIN_W:0][WIDTH-1:0] chain;
  logic [CW-1:0] cnt;
  logic mode, mode_eff, accept;
  assign chain[0] = lfsr;
  for (genvar i = 0; i < DIN_W; i++) begin : g_step
    crc_lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .d(data_in[i]),
      .lfsr_in(chain[i]),
      .lfsr_out(chain[i+1])
    );
  end
  assign next_lfsr = chain[DIN_W];
  assign gen_val = next_lfsr ^ XOR_OUT;
  assign accept = data_valid & data_ready;
  assign mode_eff = (state == IDLE) ? mode_check : mode;
  assign crc_bit = shreg[0];
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = abort ? IDLE
             : (state == SHIFT) ? ((cnt == '0) ? IDLE : SHIFT)
             : !accept ? state
             : !data_last ? ACCUM
             : mode_eff ? IDLE : SHIFT;
  end
  always_comb begin
    data_ready = (state != SHIFT);
  end
  // shreg is zero whenever no CRC is being emitted, so crc_bit idles low
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= SEED;
      shreg <= '0;
      cnt <= '0;
      mode <= 1'b0;
      crc_valid <= 1'b0;
      crc_done <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      if (abort) begin
        lfsr <= SEED;
        shreg <= '0;
        crc_valid <= 1'b0;
      end else if (state == SHIFT) begin
        shreg <= shreg >> 1;
        cnt <= cnt - CW'(1);
        crc_valid <= (cnt != '0);
        crc_done <= (cnt == CW'(1));
        if (cnt == CW'(1)) crc_err <= 1'b0;
      end else if (accept) begin
        if (state == IDLE) mode <= mode_check;
        if (!data_last) begin
          lfsr <= next_lfsr;
        end else begin
          lfsr <= SEED;
          if (mode_eff) begin
            crc_done <= 1'b1;
            crc_err <= (next_lfsr != RESIDUE);
          end else begin
            shreg <= gen_val;
            cnt <= CW'(WIDTH - 1);
            crc_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: directed and model-checked bench for the serial CRC engine
module tb_crc_serial_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic a_din = 1'b0, a_valid = 1'b0, a_last = 1'b0, a_mode = 1'b0, a_abort = 1'b0;
  logic a_ready, a_bit, a_cv, a_done, a_err;
  logic f_ready, f_bit, f_cv, f_done, f_err;
  logic [1:0] b_din = 2'b00;
  logic b_valid = 1'b0, b_last = 1'b0;
  logic b_ready, b_bit, b_cv, b_done, b_err;
  int n_chk = 0;
  int n_fail = 0;

  crc_serial_engine dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .data_valid(a_valid), .data_last(a_last),
    .mode_check(a_mode), .abort(a_abort), .data_ready(a_ready), .crc_bit(a_bit),
    .crc_valid(a_cv), .crc_done(a_done), .crc_err(a_err)
  );
  crc_serial_engine #(.SEED(8'hFF), .XOR_OUT(8'hFF)) dut_f (
    .clk(clk), .rst(rst), .data_in(a_din), .data_valid(a_valid), .data_last(a_last),
    .mode_check(a_mode), .abort(a_abort), .data_ready(f_ready), .crc_bit(f_bit),
    .crc_valid(f_cv), .crc_done(f_done), .crc_err(f_err)
  );
  crc_serial_engine #(.DIN_W(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_valid(b_valid), .data_last(b_last),
    .mode_check(1'b0), .abort(1'b0), .data_ready(b_ready), .crc_bit(b_bit),
    .crc_valid(b_cv), .crc_done(b_done), .crc_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // bit-serial reference: shift right, xor the tap mask when the feedback bit is 1
  function automatic logic [7:0] model(input logic [63:0] msg, input int n, input logic [7:0] seed);
    logic [7:0] r;
    logic fb;
    r = seed;
    for (int i = 0; i < n; i++) begin
      fb = msg[i] ^ r[0];
      r = {fb, r[7:1]} ^ (fb ? 8'h44 : 8'h00);
    end
    return r;
  endfunction

  task automatic send_a(input logic [63:0] msg, input int n, input logic chk, input bit gaps);
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b0; a_din = 1'($urandom); a_last = 1'($urandom);
        @(negedge clk);
      end
      a_valid = 1'b1; a_din = msg[i]; a_last = (i == n - 1); a_mode = chk;
      @(negedge clk);
    end
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic collect_a(output logic [7:0] ca, output logic [7:0] cf, output int nv,
                           output int done_at, output int nd, output logic err, output int rdy_bad);
    ca = '0; cf = '0; nv = 0; done_at = -1; nd = 0; err = 1'b0; rdy_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_cv) begin
        if (nv < 8) begin ca[nv] = a_bit; cf[nv] = f_bit; end
        nv++;
        if (a_ready) rdy_bad++;
      end
      if (a_done) begin
        nd++;
        if (done_at < 0) begin done_at = k; err = a_err; end
      end
      a_valid = a_cv && !a_done; a_din = 1'($urandom); a_last = 1'($urandom);
      @(negedge clk);
    end
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] msg, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b0; b_din = 2'($urandom); b_last = 1'($urandom);
        @(negedge clk);
      end
      b_valid = 1'b1; b_din = msg[2*i +: 2]; b_last = (i == 7);
      @(negedge clk);
    end
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic collect_b(output logic [7:0] cb, output int nv, output int done_at);
    cb = '0; nv = 0; done_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (b_cv) begin
        if (nv < 8) cb[nv] = b_bit;
        nv++;
      end
      if (b_done && done_at < 0) done_at = k;
      b_valid = b_cv && !b_done; b_din = 2'($urandom); b_last = 1'($urandom);
      @(negedge clk);
    end
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  initial begin
    logic [7:0] ca, cf, cb;
    int nv, done_at, nd, rdy_bad, cnt;
    logic err;
    logic [63:0] msg;
    logic [15:0] m16;
    int n;
    repeat (2) @(negedge clk);
    check("rst_outputs", {a_bit, a_cv, a_done, a_err}, 4'b0000);
    check("rst_ready", a_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    // single 1-bit message, generate: CRC 0xC4 emitted LSB-first
    send_a(64'h1, 1, 1'b0, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    check("gen1_crc", ca, 8'hC4);
    check("gen1_nvalid", nv, 8);
    check("gen1_done_at", done_at, 7);
    check("gen1_ndone", nd, 1);
    check("gen1_ready_low", rdy_bad, 0);
    check("gen1_ff_crc", cf, model(64'h1, 1, 8'hFF) ^ 8'hFF);
    // message followed by its CRC checks clean; a flipped bit errors
    send_a(64'h189, 9, 1'b1, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    check("chk_ok_done_at", done_at, 0);
    check("chk_ok_ndone", nd, 1);
    check("chk_ok_err", err, 1'b0);
    check("chk_ok_nvalid", nv, 0);
    send_a(64'h199, 9, 1'b1, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    check("chk_bad_done_at", done_at, 0);
    check("chk_bad_err", err, 1'b1);
    check("chk_bad_err_held", a_err, 1'b1);
    // reset mid-accumulation
    a_valid = 1'b1; a_din = 1'b1; a_last = 1'b0; a_mode = 1'b0;
    repeat (3) @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_outputs", {a_bit, a_cv, a_done, a_err}, 4'b0000);
    check("midrst_ready", a_ready, 1'b1);
    send_a(64'h1, 1, 1'b0, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    check("midrst_crc", ca, 8'hC4);
    // reset in the crc_done cycle of a failing check
    send_a(64'h199, 9, 1'b1, 1'b0);
    check("donerst_done", a_done, 1'b1);
    check("donerst_err", a_err, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("donerst_cleared", {a_done, a_err, a_cv}, 3'b000);
    cnt = 0;
    repeat (6) begin if (a_done || a_cv) cnt++; @(negedge clk); end
    check("donerst_quiet", cnt, 0);
    // generate frame clears a held error
    send_a(64'h199, 9, 1'b1, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    send_a(64'h1, 1, 1'b0, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    check("gen_clears_err", a_err, 1'b0);
    // abort at shift bit 3
    send_a(64'h1, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_pre_valid", a_cv, 1'b1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_valid_low", a_cv, 1'b0);
    cnt = 0;
    repeat (12) begin if (a_done || a_cv) cnt++; @(negedge clk); end
    check("abort_no_done", cnt, 0);
    send_a(64'h1, 1, 1'b0, 1'b0);
    collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
    check("abort_next_crc", ca, 8'hC4);
    // DIN_W=2 versus DIN_W=1 with gaps
    for (int t = 0; t < 4; t++) begin
      m16 = 16'($urandom);
      send_a({48'h0, m16}, 16, 1'b0, 1'b1);
      collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
      check("w1_crc", ca, model({48'h0, m16}, 16, 8'h00));
      send_b(m16, 1'b1);
      collect_b(cb, nv, done_at);
      check("w2_crc", cb, model({48'h0, m16}, 16, 8'h00));
      check("w2_done_at", done_at, 7);
    end
    // random frames against the bit-serial model, both seed/mask settings
    for (int t = 0; t < 64; t++) begin
      n = $urandom_range(1, 40);
      msg = {$urandom, $urandom};
      send_a(msg, n, 1'b0, 1'($urandom));
      collect_a(ca, cf, nv, done_at, nd, err, rdy_bad);
      check("rnd_crc", ca, model(msg, n, 8'h00));
      check("rnd_ff_crc", cf, model(msg, n, 8'hFF) ^ 8'hFF);
      check("rnd_done_at", done_at, 7);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
